// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU push side and uart_tx launch side of the transmit buffer
interface uart_tx_fifo_if #(parameter int ADDR_W = 3);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              flush;
    logic              clr_overflow;
    logic              tx_busy;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W:0]   level;
    logic              overflow;
    modport master (
        output wr_en, wr_data, flush, clr_overflow, tx_busy,
        input  tx_en, tx_data, fifo_empty, fifo_full, level, overflow
    );
    modport slave (
        input  wr_en, wr_data, flush, clr_overflow, tx_busy,
        output tx_en, tx_data, fifo_empty, fifo_full, level, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue that launches bytes into uart_tx whenever the serialiser is idle
module uart_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int GUARD  = 2
) (
    input logic clk,
    input logic rst_n,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, GUARD_S} state_t;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic [2:0]        gcnt;
    logic              tx_en_q, overflow_q;
    logic [7:0]        tx_data_q;
    logic              full, push_ok, drop, pop;
    always_comb begin
        full    = count == FULL_CNT;
        push_ok = bus.wr_en && !full && !bus.flush;
        drop    = bus.wr_en && full && !bus.flush;
        pop     = state == IDLE && count != 0 && !bus.tx_busy && !bus.flush;
    end
    // Byte storage; no reset needed since count guards every read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.wr_data;
    end
    // Pointers, count, overflow and the launch sequencer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            gcnt       <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= wr_ptr + ADDR_W'(push_ok);
                rd_ptr <= rd_ptr + ADDR_W'(pop);
                count  <= count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop);
            end
            overflow_q <= drop ? 1'b1 : bus.clr_overflow ? 1'b0 : overflow_q;
            case (state)
                IDLE: if (pop) begin
                    tx_en_q   <= 1'b1;
                    tx_data_q <= mem[rd_ptr];
                    state     <= LAUNCH;
                end
                LAUNCH: begin
                    tx_en_q <= 1'b0;
                    gcnt    <= 3'(GUARD - 1);
                    state   <= GUARD_S;
                end
                default: begin
                    gcnt  <= gcnt - 3'd1;
                    state <= gcnt == 3'd0 ? IDLE : GUARD_S;
                end
            endcase
        end
    end
    assign bus.tx_en      = tx_en_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_empty = count == 0;
    assign bus.fifo_full  = full;
    assign bus.level      = count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios for the UART transmit buffer with a 10-cycle busy serialiser model
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_busy = 1'b0;
    int busy_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] sent[$];
    logic [7:0] ref_q[$];
    uart_tx_fifo_if #(.ADDR_W(3)) bus ();
    uart_tx_fifo #(.DEPTH(8), .ADDR_W(3), .GUARD(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign bus.tx_busy = force_busy | (busy_cnt != 0);
    // Serialiser model: records each launched byte and stays busy for 10 cycles
    always @(negedge clk) begin
        if (rst_n && bus.tx_en) begin
            sent.push_back(bus.tx_data);
            busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask
    task automatic test_reset();
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush = 1'b0;
        bus.clr_overflow = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
        n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.fifo_empty); end
        n_checks++; if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.fifo_full); end
        n_checks++; if (bus.tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b expected 0", bus.tx_en); end
        n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        rst_n = 1'b1;
        sent.delete();
        repeat (50) tick();
        n_checks++; if (sent.size() !== 0) begin n_fail++; $display("FAIL idle_no_launch: got %0d launches expected 0", sent.size()); end
        n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL idle_empty: got %b expected 1", bus.fifo_empty); end
    endtask
    task automatic test_single();
        push(8'hA5);
        n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL single_level1: got %0d expected 1", bus.level); end
        n_checks++; if (bus.tx_en !== 1'b0) begin n_fail++; $display("FAIL single_early_tx_en: got %b expected 0", bus.tx_en); end
        tick();
        n_checks++; if (bus.tx_en !== 1'b1) begin n_fail++; $display("FAIL single_tx_en: got %b expected 1", bus.tx_en); end
        n_checks++; if (bus.tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %h expected a5", bus.tx_data); end
        n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL single_level0: got %0d expected 0", bus.level); end
        tick();
        n_checks++; if (bus.tx_en !== 1'b0) begin n_fail++; $display("FAIL single_tx_en_drop: got %b expected 0", bus.tx_en); end
        n_checks++; if (bus.tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data_hold: got %h expected a5", bus.tx_data); end
        repeat (15) tick();
    endtask
    task automatic test_overflow();
        int t;
        force_busy = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        n_checks++; if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", bus.fifo_full); end
        n_checks++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL ovf_level8: got %0d expected 8", bus.level); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", bus.overflow); end
        push(8'h09);
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
        n_checks++; if (bus.level !== 4'd8) begin n_fail++; $display("FAIL ovf_level_hold: got %0d expected 8", bus.level); end
        sent.delete();
        force_busy = 1'b0;
        t = 0;
        while (sent.size() < 8 && t < 400) begin tick(); t++; end
        n_checks++; if (t >= 400) begin n_fail++; $display("FAIL ovf_drain_timeout: got %0d bytes expected 8", sent.size()); end
        repeat (30) tick();
        n_checks++; if (sent.size() !== 8) begin n_fail++; $display("FAIL ovf_count: got %0d bytes expected 8", sent.size()); end
        for (int i = 0; i < 8 && i < sent.size(); i++) begin
            n_checks++; if (sent[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, sent[i], 8'(i + 1)); end
        end
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
    endtask
    task automatic test_flush();
        repeat (15) tick();
        force_busy = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        n_checks++; if (bus.level !== 4'd3) begin n_fail++; $display("FAIL flush_level3: got %0d expected 3", bus.level); end
        bus.flush = 1'b1;
        push(8'h44);
        bus.flush = 1'b0;
        n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL flush_level0: got %0d expected 0", bus.level); end
        n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b expected 1", bus.fifo_empty); end
        sent.delete();
        force_busy = 1'b0;
        repeat (30) tick();
        n_checks++; if (sent.size() !== 0) begin n_fail++; $display("FAIL flush_no_launch: got %0d launches expected 0", sent.size()); end
    endtask
    task automatic test_wrap();
        logic [7:0] d;
        int t;
        ref_q.delete();
        sent.delete();
        force_busy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            d = 8'($urandom);
            ref_q.push_back(d);
            push(d);
        end
        d = 8'($urandom);
        ref_q.push_back(d);
        force_busy = 1'b0;
        push(d);
        n_checks++; if (bus.level !== 4'd7) begin n_fail++; $display("FAIL wrap_level_same: got %0d expected 7", bus.level); end
        n_checks++; if (bus.tx_en !== 1'b1) begin n_fail++; $display("FAIL wrap_launch: got %b expected 1", bus.tx_en); end
        n_checks++; if (bus.tx_data !== ref_q[0]) begin n_fail++; $display("FAIL wrap_first: got %h expected %h", bus.tx_data, ref_q[0]); end
        for (int i = 8; i < 20; i++) begin
            t = 0;
            while (bus.fifo_full && t < 100) begin tick(); t++; end
            d = 8'($urandom);
            ref_q.push_back(d);
            push(d);
        end
        t = 0;
        while (sent.size() < 20 && t < 600) begin tick(); t++; end
        n_checks++; if (sent.size() !== 20) begin n_fail++; $display("FAIL wrap_count: got %0d bytes expected 20", sent.size()); end
        for (int i = 0; i < 20 && i < sent.size(); i++) begin
            n_checks++; if (sent[i] !== ref_q[i]) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, sent[i], ref_q[i]); end
        end
    endtask
    task automatic test_reset_guard();
        int t;
        repeat (15) tick();
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        sent.delete();
        force_busy = 1'b0;
        t = 0;
        while (!bus.tx_en && t < 20) begin tick(); t++; end
        n_checks++; if (bus.tx_en !== 1'b1) begin n_fail++; $display("FAIL rstg_launch: got %b expected 1", bus.tx_en); end
        tick();
        n_checks++; if (bus.level !== 4'd4) begin n_fail++; $display("FAIL rstg_level4: got %0d expected 4", bus.level); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL rstg_level0: got %0d expected 0", bus.level); end
        n_checks++; if (bus.tx_en !== 1'b0) begin n_fail++; $display("FAIL rstg_tx_en: got %b expected 0", bus.tx_en); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rstg_overflow: got %b expected 0", bus.overflow); end
        repeat (40) tick();
        n_checks++; if (sent.size() !== 1) begin n_fail++; $display("FAIL rstg_no_more: got %0d launches expected 1", sent.size()); end
    endtask
    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_flush();
        test_wrap();
        test_reset_guard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
